// File: rtl/fifo_v3_if.sv
// rtl/fifo_v3_if.sv - handshake bundle between a fifo_v3 and its user
interface fifo_v3_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int UW = $clog2(DEPTH + 1);

  logic             flush_i;
  logic             push_i;
  logic [WIDTH-1:0] data_i;
  logic             pop_i;
  logic [WIDTH-1:0] data_o;
  logic             full_o;
  logic             empty_o;
  logic             alm_full_o;
  logic             alm_empty_o;
  logic [UW-1:0]    usage_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output flush_i, push_i, data_i, pop_i,
    input  data_o, full_o, empty_o, alm_full_o, alm_empty_o, usage_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, push_i, data_i, pop_i,
    output data_o, full_o, empty_o, alm_full_o, alm_empty_o, usage_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - portable single-clock FIFO, any depth, show-ahead or registered read
module fifo_v3 #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int ALM_FULL_TH  = DEPTH - 1,
  parameter int ALM_EMPTY_TH = 1,
  parameter int FWFT         = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  fifo_v3_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_chk_depth
    $error("fifo_v3: DEPTH must be at least 2");
  end
  if (ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH) begin : g_chk_afull
    $error("fifo_v3: ALM_FULL_TH out of range");
  end
  if (ALM_EMPTY_TH < 0 || ALM_EMPTY_TH > DEPTH - 1) begin : g_chk_aempty
    $error("fifo_v3: ALM_EMPTY_TH out of range");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_chk_fwft
    $error("fifo_v3: FWFT must be 0 or 1");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [UW-1:0]    r_usage;
  logic             r_full;
  logic             r_empty;
  logic             r_alm_full;
  logic             r_alm_empty;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [PW-1:0]    w_wptr_inc;
  logic [PW-1:0]    w_rptr_inc;
  logic [UW-1:0]    w_usage_nxt;

  assign w_pop_ok   = bus.pop_i & ~bus.flush_i & ~r_empty;
  assign w_push_ok  = bus.push_i & ~bus.flush_i & (~r_full | w_pop_ok);
  assign w_wptr_inc = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_inc = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  always_comb begin
    w_usage_nxt = r_usage;
    if (bus.flush_i) begin
      w_usage_nxt = '0;
    end else if (w_push_ok && !w_pop_ok) begin
      w_usage_nxt = r_usage + UW'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_usage_nxt = r_usage - UW'(1);
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_usage     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_alm_full  <= 1'b0;
      r_alm_empty <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push_ok) r_wptr <= w_wptr_inc;
        if (w_pop_ok)  r_rptr <= w_rptr_inc;
      end
      r_usage     <= w_usage_nxt;
      r_full      <= (w_usage_nxt == UW'(DEPTH));
      r_empty     <= (w_usage_nxt == '0);
      r_alm_full  <= (w_usage_nxt >= UW'(ALM_FULL_TH));
      r_alm_empty <= (w_usage_nxt <= UW'(ALM_EMPTY_TH));
      r_overflow  <= bus.push_i & r_full & ~w_pop_ok & ~bus.flush_i;
      r_underflow <= bus.pop_i & r_empty & ~bus.flush_i;
    end
  end

  if (FWFT == 1) begin : g_fwft
    // Gated by empty so the output reads zero out of reset despite uncleared storage.
    assign bus.data_o = r_empty ? '0 : r_mem[r_rptr];
  end else begin : g_regread
    logic [WIDTH-1:0] r_data;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_data <= '0;
      end else if (w_pop_ok) begin
        r_data <= r_mem[r_rptr];
      end
    end
    assign bus.data_o = r_data;
  end

  assign bus.full_o      = r_full;
  assign bus.empty_o     = r_empty;
  assign bus.alm_full_o  = r_alm_full;
  assign bus.alm_empty_o = r_alm_empty;
  assign bus.usage_o     = r_usage;
  assign bus.overflow_o  = r_overflow;
  assign bus.underflow_o = r_underflow;
endmodule

// File: tb/tb_fifo_v3.sv
// tb/tb_fifo_v3.sv - directed checks of fifo_v3 in show-ahead and registered-read builds
module tb_fifo_v3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fifo_v3_if #(.WIDTH(8), .DEPTH(8)) b8 ();
  fifo_v3_if #(.WIDTH(8), .DEPTH(5)) b5 ();
  fifo_v3_if #(.WIDTH(8), .DEPTH(4)) b0 ();

  fifo_v3 #(.WIDTH(8), .DEPTH(8), .FWFT(1)) u8 (.clk_i(clk), .rst_i(rst), .bus(b8));
  fifo_v3 #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u5 (.clk_i(clk), .rst_i(rst), .bus(b5));
  fifo_v3 #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q [$];

  initial begin
    b8.flush_i = 0; b8.push_i = 0; b8.pop_i = 0; b8.data_i = 0;
    b5.flush_i = 0; b5.push_i = 0; b5.pop_i = 0; b5.data_i = 0;
    b0.flush_i = 0; b0.push_i = 0; b0.pop_i = 0; b0.data_i = 0;
    step();
    step();
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      step();
      check("rst_usage", 32'(b8.usage_o), 0);
      check("rst_empty", 32'(b8.empty_o), 1);
      check("rst_aempty", 32'(b8.alm_empty_o), 1);
      check("rst_full", 32'(b8.full_o), 0);
      check("rst_data", 32'(b8.data_o), 0);
    end

    b8.push_i = 1; b8.data_i = 8'hA5;
    step();
    b8.push_i = 0;
    check("fwft_empty", 32'(b8.empty_o), 0);
    check("fwft_data", 32'(b8.data_o), 32'hA5);
    check("fwft_usage", 32'(b8.usage_o), 1);
    b8.pop_i = 1;
    step();
    b8.pop_i = 0;
    check("fwft_pop_empty", 32'(b8.empty_o), 1);
    check("fwft_pop_usage", 32'(b8.usage_o), 0);

    for (int i = 1; i <= 5; i++) begin
      b5.push_i = 1; b5.data_i = 8'(i);
      step();
      check("fill_usage", 32'(b5.usage_o), 32'(i));
      check("fill_afull", 32'(b5.alm_full_o), (i >= 4) ? 1 : 0);
      check("fill_full", 32'(b5.full_o), (i == 5) ? 1 : 0);
    end
    b5.data_i = 8'h06;
    step();
    b5.push_i = 0;
    check("ovf_pulse", 32'(b5.overflow_o), 1);
    check("ovf_usage", 32'(b5.usage_o), 5);
    step();
    check("ovf_end", 32'(b5.overflow_o), 0);
    for (int i = 1; i <= 5; i++) begin
      check("drain_data", 32'(b5.data_o), 32'(i));
      b5.pop_i = 1;
      step();
    end
    b5.pop_i = 0;
    check("drain_empty", 32'(b5.empty_o), 1);
    check("drain_usage", 32'(b5.usage_o), 0);

    for (int k = 0; k < 12; k++) begin
      b5.push_i = 1; b5.data_i = 8'(8'h10 + k);
      step();
      b5.push_i = 0;
      check("wrap_usage", 32'(b5.usage_o), 1);
      check("wrap_data", 32'(b5.data_o), 32'(8'h10 + k));
      b5.pop_i = 1;
      step();
      b5.pop_i = 0;
      check("wrap_usage0", 32'(b5.usage_o), 0);
    end

    for (int i = 0; i < 5; i++) begin
      b5.push_i = 1; b5.data_i = 8'(8'h21 + i);
      step();
    end
    b5.data_i = 8'h77; b5.pop_i = 1;
    step();
    b5.push_i = 0; b5.pop_i = 0;
    check("fullpp_usage", 32'(b5.usage_o), 5);
    check("fullpp_ovf", 32'(b5.overflow_o), 0);
    exp_q = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h77};
    foreach (exp_q[i]) begin
      check("fullpp_data", 32'(b5.data_o), 32'(exp_q[i]));
      b5.pop_i = 1;
      step();
    end
    b5.pop_i = 0;
    check("fullpp_empty", 32'(b5.empty_o), 1);

    b5.push_i = 1; b5.data_i = 8'h33; b5.pop_i = 1;
    step();
    b5.push_i = 0; b5.pop_i = 0;
    check("udf_pulse", 32'(b5.underflow_o), 1);
    check("udf_usage", 32'(b5.usage_o), 1);
    check("udf_data", 32'(b5.data_o), 32'h33);
    step();
    check("udf_end", 32'(b5.underflow_o), 0);
    b5.pop_i = 1;
    step();
    b5.pop_i = 0;

    for (int i = 0; i < 3; i++) begin
      b5.push_i = 1; b5.data_i = 8'(8'h41 + i);
      step();
    end
    check("fl_pre_usage", 32'(b5.usage_o), 3);
    b5.flush_i = 1; b5.data_i = 8'h99;
    step();
    b5.flush_i = 0; b5.push_i = 0;
    check("fl_usage", 32'(b5.usage_o), 0);
    check("fl_empty", 32'(b5.empty_o), 1);
    check("fl_aempty", 32'(b5.alm_empty_o), 1);
    b5.push_i = 1; b5.data_i = 8'h55;
    step();
    b5.push_i = 0;
    check("fl_next_data", 32'(b5.data_o), 32'h55);
    check("fl_next_usage", 32'(b5.usage_o), 1);
    b5.pop_i = 1;
    step();
    b5.pop_i = 0;

    for (int i = 0; i < 3; i++) begin
      b5.push_i = 1; b5.data_i = 8'(8'h61 + i);
      step();
    end
    b5.push_i = 0;
    check("ar_pre_usage", 32'(b5.usage_o), 3);
    rst = 1'b1;
    #2;
    check("ar_usage", 32'(b5.usage_o), 0);
    check("ar_empty", 32'(b5.empty_o), 1);
    check("ar_full", 32'(b5.full_o), 0);
    check("ar_aempty", 32'(b5.alm_empty_o), 1);
    check("ar_afull", 32'(b5.alm_full_o), 0);
    rst = 1'b0;
    b5.push_i = 1; b5.data_i = 8'h71;
    step();
    b5.push_i = 0;
    check("ar_first_data", 32'(b5.data_o), 32'h71);
    check("ar_first_usage", 32'(b5.usage_o), 1);

    check("reg_rst_data", 32'(b0.data_o), 0);
    b0.push_i = 1; b0.data_i = 8'h01;
    step();
    b0.data_i = 8'h02;
    step();
    b0.push_i = 0;
    step();
    check("reg_nopop_data", 32'(b0.data_o), 0);
    check("reg_usage2", 32'(b0.usage_o), 2);
    b0.pop_i = 1;
    step();
    b0.pop_i = 0;
    check("reg_pop_data", 32'(b0.data_o), 32'h01);
    check("reg_pop_usage", 32'(b0.usage_o), 1);
    step();
    step();
    check("reg_hold_data", 32'(b0.data_o), 32'h01);
    b0.pop_i = 1;
    step();
    b0.pop_i = 0;
    check("reg_pop2_data", 32'(b0.data_o), 32'h02);
    check("reg_pop2_empty", 32'(b0.empty_o), 1);
    b0.pop_i = 1;
    step();
    b0.pop_i = 0;
    check("reg_udf", 32'(b0.underflow_o), 1);
    check("reg_empty_hold", 32'(b0.data_o), 32'h02);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_v3.md
Name: fifo_v3

Overview:
Portable, parametrised single-clock FIFO that replaces the vendor-primitive FIFO wrapper used by the CPU and peripheral datapaths.
- Inferred register/RAM storage; no device-family dependency.
- Arbitrary (non-power-of-two) depth.
- Programmable almost-full/almost-empty thresholds and a fill-level output.
- Selectable show-ahead (FWFT) or registered-read mode.
- One-cycle overflow/underflow error pulses.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, any integer)
ALM_FULL_TH, DEPTH-1, alm_full_o asserted when usage_o >= ALM_FULL_TH (1..DEPTH)
ALM_EMPTY_TH, 1, alm_empty_o asserted when usage_o <= ALM_EMPTY_TH (0..DEPTH-1)
FWFT, 1, 1 = show-ahead read (head word on data_o while !empty_o); 0 = registered read (word appears the cycle after pop)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
flush_i  in  1  synchronous clear of contents; has priority over push/pop
push_i  in  1  write request
data_i  in  WIDTH  write data
pop_i  in  1  read request
data_o  out  WIDTH  read data
full_o  out  1  usage_o == DEPTH
empty_o  out  1  usage_o == 0
alm_full_o  out  1  usage_o >= ALM_FULL_TH
alm_empty_o  out  1  usage_o <= ALM_EMPTY_TH
usage_o  out  $clog2(DEPTH+1)  current number of stored words
overflow_o  out  1  one-cycle pulse: push_i while full and not accepted
underflow_o  out  1  one-cycle pulse: pop_i while empty

Behaviour:
- Reset (rst_i high, asynchronous): write/read pointers = 0, usage_o = 0, empty_o = 1, full_o = 0, alm_empty_o = 1, alm_full_o = 0, data_o = 0, overflow_o = 0, underflow_o = 0. Storage contents are not cleared.
- Reset asserted mid-transfer discards all contents immediately. The first push after release behaves as a push into an empty FIFO.
- Pointers increment modulo DEPTH with an explicit wrap compare (ptr == DEPTH-1 -> 0). Never use bit truncation.
- Flags are registered, derived from the next-state count, and valid in the same cycle as usage_o.
- push_ok = push_i & !flush_i & (!full_o | pop_ok).
  - Push is accepted when full only if a pop is accepted in the same cycle.
  - On accept: the word is written at wptr and wptr advances.
- pop_ok = pop_i & !flush_i & !empty_o.
  - Pop into an empty FIFO is rejected even with a simultaneous push.
  - The pushed word is stored; underflow_o pulses.
- usage_o next = usage_o + push_ok - pop_ok. It never exceeds DEPTH and never wraps below 0.
- overflow_o pulses on push_i & full_o & !pop_ok & !flush_i; the word is dropped.
- underflow_o pulses on pop_i & empty_o & !flush_i.
- flush_i: next cycle, pointers = 0, usage_o = 0, flags at reset values, error pulses 0. push_i/pop_i in the flush cycle are ignored. data_o holds its value in FWFT=0 and is don't-care in FWFT=1.
- FWFT=1 read path:
  - data_o = mem[rptr], combinational from storage; valid whenever !empty_o.
  - Write to an empty FIFO: data_o valid and empty_o low on the next cycle (1-cycle latency).
  - After pop_ok, data_o shows the next word in the following cycle.
- FWFT=0 read path:
  - data_o is a register loaded with mem[rptr] on pop_ok, so the word is visible the cycle after pop.
  - data_o holds its value otherwise, including when empty.
- Simultaneous push_ok & pop_ok with 0 < usage < DEPTH: usage unchanged; both pointers advance.
- Elaboration check: error if DEPTH < 2, if either threshold is out of range, or if FWFT is not in {0,1}.

Test Plan:
- Reset then idle, DEPTH=8: after rst_i release -> usage_o=0, empty_o=1, alm_empty_o=1, full_o=0, data_o=0 for 5 cycles.
- FWFT=1: push 0xA5 at cycle 0 -> cycle 1: empty_o=0, data_o=0xA5, usage_o=1. Pop at cycle 1 -> cycle 2: empty_o=1, usage_o=0.
- Fill, DEPTH=5, pushes 1..5:
  - usage_o counts 1..5; alm_full_o rises at usage 4; full_o rises at 5.
  - Sixth push -> overflow_o pulse, usage_o stays 5.
  - Pop all -> data order 1,2,3,4,5.
- Wrap with DEPTH=5 (non-power-of-two): 12 interleaved push/pop pairs of values 0x10..0x1B -> output order 0x10..0x1B, usage_o never exceeds 1.
- Full FIFO with simultaneous push 0x77 and pop -> usage_o stays DEPTH, no overflow_o, 0x77 read out last.
- Empty FIFO with push 0x33 and pop together -> underflow_o pulse; usage_o=1; data_o=0x33 next cycle (FWFT=1).
- Flush and async reset with usage_o=3:
  - flush_i with push_i=1 -> next cycle usage_o=0, empty_o=1, pushed word not stored.
  - rst_i pulsed mid-cycle at usage 3 -> flags return to reset values before the next clock edge.
- FWFT=0: push 0x01, 0x02; pop at cycle 3 -> data_o=0x01 at cycle 4; data_o holds 0x01 until the next pop.
